// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: axis phase encoding, 640x480@60 timing
// constants and the debug view of both phase FSMs.
package vga_pkg;
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int POS_W       = 10;
  localparam int CLK_DIV_DEF = 4;

  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOTAL    = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOTAL    = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    phase_t h_phase;
    phase_t v_phase;
  } dbg_t;
endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster output bundle of the VGA sequencer plus its run enable.
// en is sampled every clk; all other signals are registered levels/pulses.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  logic             en;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic             pix_tick;
  logic             line_end;
  logic             frame_start;
  dbg_t             dbg;

  modport master (
    input  en,
    output hsync, vsync, video_on, x, y, pix_tick, line_end, frame_start, dbg
  );

  modport slave (
    output en,
    input  hsync, vsync, video_on, x, y, pix_tick, line_end, frame_start, dbg
  );
endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Both advance only on step; wrap flags the last position of the axis.
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int ACT  = 640,
  parameter int FP   = 16,
  parameter int SYNC = 96,
  parameter int BP   = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [POS_W-1:0] pos,
  output phase_t           phase,
  output logic             wrap
);
  localparam int TOTAL = ACT + FP + SYNC + BP;
  localparam logic [POS_W-1:0] LAST   = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] B_ACT  = POS_W'(ACT - 1);
  localparam logic [POS_W-1:0] B_FP   = POS_W'(ACT + FP - 1);
  localparam logic [POS_W-1:0] B_SYNC = POS_W'(ACT + FP + SYNC - 1);

  assign wrap = (pos == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos   <= '0;
      phase <= PH_ACTIVE;
    end else if (step) begin
      pos <= wrap ? '0 : pos + 1'b1;
      // Phase leaves on the step where pos sits on the last value of the phase.
      case (phase)
        PH_ACTIVE: if (pos == B_ACT)  phase <= PH_FRONT;
        PH_FRONT:  if (pos == B_FP)   phase <= PH_SYNC;
        PH_SYNC:   if (pos == B_SYNC) phase <= PH_BACK;
        PH_BACK:   if (pos == LAST)   phase <= PH_ACTIVE;
        default:                      phase <= PH_ACTIVE;
      endcase
    end
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel-tick divider, H/V axis timers and the
// registered sync/video/position/strobe outputs (one clk behind the state).
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input logic                clk,
  input logic                reset,
  vga_timing_ctrl_if.master  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [POS_W-1:0] h_pos, v_pos;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             v_step;

  // With CLK_DIV=1 DIV_LAST is 0 and div never leaves 0, so every enabled clk ticks.
  assign tick   = bus.en && (div == DIV_LAST);
  assign v_step = tick && h_wrap;

  always_ff @(posedge clk) begin
    if (reset) div <= '0;
    else if (bus.en) div <= tick ? '0 : div + 1'b1;
  end

  vga_axis_timer #(.ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk   (clk),
    .reset (reset),
    .step  (tick),
    .pos   (h_pos),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_timer #(.ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk   (clk),
    .reset (reset),
    .step  (v_step),
    .pos   (v_pos),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // Levels hold while en is low; strobes are forced low.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.video_on    <= 1'b0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.pix_tick    <= 1'b0;
      bus.line_end    <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.en) begin
      bus.hsync       <= (h_phase != PH_SYNC);
      bus.vsync       <= (v_phase != PH_SYNC);
      bus.video_on    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      bus.x           <= h_pos;
      bus.y           <= v_pos;
      bus.pix_tick    <= tick;
      bus.line_end    <= tick && h_wrap;
      bus.frame_start <= tick && h_wrap && v_wrap;
    end else begin
      bus.pix_tick    <= 1'b0;
      bus.line_end    <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end

  assign bus.dbg = '{h_phase: h_phase, v_phase: v_phase};
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size CLK_DIV=4 instance and a shrunken
// CLK_DIV=1 instance share stimulus; a pixel-count model feeds per-DUT queues.
module tb_vga_timing_ctrl;
  import vga_pkg::*;

  localparam int W = 26;

  logic clk;
  logic reset;

  vga_timing_ctrl_if ifa ();
  vga_timing_ctrl_if ifb ();

  vga_timing_ctrl dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.master)
  );

  vga_timing_ctrl #(
    .CLK_DIV(1),
    .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(8),  .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int div_k[2] = '{4, 1};
  int ha[2] = '{640, 16};
  int hf[2] = '{16, 2};
  int hs[2] = '{96, 3};
  int hb[2] = '{48, 3};
  int va[2] = '{480, 8};
  int vf[2] = '{10, 2};
  int vs[2] = '{2, 2};
  int vb[2] = '{33, 2};

  int            en_clks[2];   // enabled clks since reset
  logic [W-1:0]  last_exp[2];
  logic [W-1:0]  exp_qa[$];
  logic [W-1:0]  exp_qb[$];

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Expected outputs describe the raster position t pixels after reset.
  function automatic logic [W-1:0] ref_out(int k, int t, bit tk);
    int htot, vtot, px, py;
    bit hsy, vsy, von, le, fs;
    htot = ha[k] + hf[k] + hs[k] + hb[k];
    vtot = va[k] + vf[k] + vs[k] + vb[k];
    px   = t % htot;
    py   = (t / htot) % vtot;
    hsy  = !(px >= ha[k] + hf[k] && px < ha[k] + hf[k] + hs[k]);
    vsy  = !(py >= va[k] + vf[k] && py < va[k] + vf[k] + vs[k]);
    von  = (px < ha[k]) && (py < va[k]);
    le   = tk && (px == htot - 1);
    fs   = le && (py == vtot - 1);
    return {hsy, vsy, von, 10'(px), 10'(py), tk, le, fs};
  endfunction

  task automatic model_step(input int k, input bit r, input bit e);
    logic [W-1:0] ex;
    int t_before;
    if (r) begin
      en_clks[k] = 0;
      ex = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};
    end else if (e) begin
      t_before   = en_clks[k] / div_k[k];
      en_clks[k] = en_clks[k] + 1;
      ex = ref_out(k, t_before, (en_clks[k] % div_k[k]) == 0);
    end else begin
      ex = {last_exp[k][W-1:3], 3'b000};
    end
    last_exp[k] = ex;
    if (k == 0) exp_qa.push_back(ex);
    else        exp_qb.push_back(ex);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e);
    @(negedge clk);
    reset  = r;
    ifa.en = e;
    ifb.en = e;
    model_step(0, r, e);
    model_step(1, r, e);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_one(input string name, input logic [W-1:0] got,
                           input logic [W-1:0] ex);
    total_cnt++;
    if (got !== ex) begin
      bad_cnt++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, ex);
    end
  endtask

  initial begin
    logic [W-1:0] ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_qa.size() > 0) begin
        ex = exp_qa.pop_front();
        check_one("dut_a_out", {ifa.hsync, ifa.vsync, ifa.video_on, ifa.x, ifa.y,
                                ifa.pix_tick, ifa.line_end, ifa.frame_start}, ex);
      end
      if (exp_qb.size() > 0) begin
        ex = exp_qb.pop_front();
        check_one("dut_b_out", {ifb.hsync, ifb.vsync, ifb.video_on, ifb.x, ifb.y,
                                ifb.pix_tick, ifb.line_end, ifb.frame_start}, ex);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset  = 1'b1;
    ifa.en = 1'b0;
    ifb.en = 1'b0;

    repeat (3) drive(1'b1, 1'b0);
    // Slightly more than one full-size line at CLK_DIV=4.
    repeat (3300) drive(1'b0, 1'b1);

    // Park dut_a inside hsync, then hold en low for 37 clks.
    waited = 0;
    while (ifa.x != 10'd700 && waited < 4000) begin
      drive(1'b0, 1'b1);
      waited++;
    end
    total_cnt++;
    if (waited >= 4000) begin
      bad_cnt++;
      $display("FAIL wait_x700 got_x=%0d want_x=700", ifa.x);
    end
    repeat (37) drive(1'b0, 1'b0);
    repeat (500) drive(1'b0, 1'b1);

    // Random enable gaps with occasional mid-raster resets.
    repeat (4000) begin
      drive($urandom_range(0, 799) == 0, $urandom_range(0, 7) != 0);
    end

    // Reset while dut_b sits in vsync, then restart cleanly.
    waited = 0;
    while (ifb.vsync != 1'b0 && waited < 2000) begin
      drive(1'b0, 1'b1);
      waited++;
    end
    total_cnt++;
    if (waited >= 2000) begin
      bad_cnt++;
      $display("FAIL wait_vsync got_vsync=%0b want_vsync=0", ifb.vsync);
    end
    repeat (2) drive(1'b1, 1'b1);
    repeat (1500) drive(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    total_cnt++;
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      bad_cnt++;
      $display("FAIL queue_drain got=%0d/%0d want=0/0", exp_qa.size(), exp_qb.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
